// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fetch_lane_t;

  localparam fetch_lane_t EMPTY_LANE = '{valid: 1'b0, inst: NOP, pc: '0};

endpackage

// File: rtl/fetch_align.sv
// Splits a fetched doubleword into instruction lanes and computes the following PC.
module fetch_align import fetch_pkg::*; #(
  parameter int FETCH_WIDTH = 2
) (
  input  logic [XLEN-1:0]                i_pc,
  input  logic [63:0]                    i_data,
  output fetch_lane_t [FETCH_WIDTH-1:0]  o_lanes,
  output logic [XLEN-1:0]                o_next_pc
);

  if (FETCH_WIDTH == 2) begin : g_dual
    // An odd-word PC only has one instruction left in the doubleword.
    always_comb begin
      o_lanes[0].valid = 1'b1;
      o_lanes[0].inst  = i_pc[2] ? i_data[63:32] : i_data[31:0];
      o_lanes[0].pc    = i_pc;
      if (i_pc[2]) begin
        o_lanes[1] = EMPTY_LANE;
        o_next_pc  = i_pc + XLEN'(4);
      end else begin
        o_lanes[1].valid = 1'b1;
        o_lanes[1].inst  = i_data[63:32];
        o_lanes[1].pc    = i_pc + XLEN'(4);
        o_next_pc        = i_pc + XLEN'(8);
      end
    end
  end else begin : g_single
    always_comb begin
      o_lanes[0].valid = 1'b1;
      o_lanes[0].inst  = i_pc[2] ? i_data[63:32] : i_data[31:0];
      o_lanes[0].pc    = i_pc;
      o_next_pc        = i_pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding doubleword read, aligned into a bundle that is
// held until the consumer takes it; redirects squash everything in flight.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN        = 32,
  parameter int              FETCH_WIDTH = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_redirect_valid,
  input  logic [XLEN-1:0]             i_redirect_pc,
  input  logic                        i_stall,
  output logic                        o_mem_req_valid,
  output logic [XLEN-1:0]             o_mem_req_addr,
  input  logic                        i_mem_req_ready,
  input  logic                        i_mem_rsp_valid,
  input  logic [63:0]                 i_mem_rsp_data,
  output logic [FETCH_WIDTH-1:0]      o_out_valid,
  output logic [FETCH_WIDTH*32-1:0]   o_out_inst,
  output logic [FETCH_WIDTH*XLEN-1:0] o_out_pc,
  input  logic                        i_out_ready
);

  localparam fetch_lane_t [FETCH_WIDTH-1:0] NO_LANES = {FETCH_WIDTH{EMPTY_LANE}};

  fetch_state_e                  r_state, w_state_n;
  logic [XLEN-1:0]               r_pc, w_pc_n, r_next_pc, w_next_pc_n, w_align_next;
  logic                          r_drop, w_drop_n, w_req_fire, w_xfer;
  fetch_lane_t [FETCH_WIDTH-1:0] r_lanes, w_lanes_n, w_align_lanes;

  fetch_align #(.FETCH_WIDTH(FETCH_WIDTH)) u_align (
    .i_pc      (r_pc),
    .i_data    (i_mem_rsp_data),
    .o_lanes   (w_align_lanes),
    .o_next_pc (w_align_next)
  );

  // A pending drop means a stale response is still coming; hold off new requests.
  assign o_mem_req_valid = (r_state == ST_REQ) && !i_stall && !i_redirect_valid &&
                           !r_drop && !reset;
  assign o_mem_req_addr  = {r_pc[XLEN-1:3], 3'b000};
  assign w_req_fire      = o_mem_req_valid && i_mem_req_ready;
  assign w_xfer          = (r_state == ST_HOLD) && i_out_ready && (|o_out_valid);

  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_next_pc_n = r_next_pc;
    w_lanes_n   = r_lanes;
    w_drop_n    = r_drop && !i_mem_rsp_valid;
    if (i_redirect_valid) begin
      w_state_n = ST_REQ;
      w_pc_n    = i_redirect_pc;
      w_lanes_n = NO_LANES;
      if ((r_state == ST_WAIT) && !i_mem_rsp_valid) begin
        w_drop_n = 1'b1;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_req_fire) begin
            w_state_n = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_rsp_valid) begin
            w_state_n   = ST_HOLD;
            w_lanes_n   = w_align_lanes;
            w_next_pc_n = w_align_next;
          end
        end
        ST_HOLD: begin
          if (w_xfer) begin
            w_state_n = ST_REQ;
            w_pc_n    = r_next_pc;
            w_lanes_n = NO_LANES;
          end
        end
        default: w_state_n = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_REQ;
      r_pc      <= RESET_PC;
      r_next_pc <= RESET_PC;
      r_drop    <= 1'b0;
      r_lanes   <= NO_LANES;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_next_pc <= w_next_pc_n;
      r_drop    <= w_drop_n;
      r_lanes   <= w_lanes_n;
    end
  end

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_out
    assign o_out_valid[i]             = r_lanes[i].valid;
    assign o_out_inst[i*32 +: 32]     = r_lanes[i].inst;
    assign o_out_pc[i*XLEN +: XLEN]   = r_lanes[i].pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic on a two-lane and a
// one-lane instance, checked against a PC-stream model of what the consumer should see.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, redir_v, stall, out_ready, rand_mem;
  logic [31:0] redir_pc;
  int          lat_cfg;
  int          total = 0;
  int          bad   = 0;

  logic        req_v_a [2];
  logic        rdy_a   [2];
  logic [31:0] req_a_a [2];
  logic [1:0]  ov      [2];
  logic [63:0] oi      [2];
  logic [63:0] op      [2];

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory contents: the word at byte address a is a scramble of a.
  function automatic logic [31:0] mword(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // What the consumer should receive for a bundle starting at pc.
  function automatic void model_bundle(int fw, logic [31:0] pc, output logic [1:0] v,
                                       output logic [63:0] inst, output logic [63:0] pcs,
                                       output logic [31:0] nxt);
    v    = 2'b01;
    inst = {32'h0000_0013, mword(pc)};
    pcs  = {32'h0, pc};
    nxt  = pc + 32'd4;
    if (fw == 1) begin
      inst[63:32] = 32'h0;
    end else if (pc % 8 == 0) begin
      v    = 2'b11;
      inst = {mword(pc + 32'd4), mword(pc)};
      pcs  = {pc + 32'd4, pc};
      nxt  = pc + 32'd8;
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int FW = (g == 0) ? 2 : 1;
    logic             req_v;
    logic [31:0]      req_a;
    logic             rdy    = 1'b1;
    logic             rsp_v  = 1'b0;
    logic [63:0]      rsp_d  = '0;
    logic             busy   = 1'b0;
    logic [31:0]      m_addr = '0;
    int               m_lat  = 0;
    int               nx     = 0;
    logic [FW-1:0]    w_ov;
    logic [FW*32-1:0] w_oi, w_op;
    logic [31:0]      mpc = '0, en;
    logic             hold_prev = 1'b0, xfer, acc;
    logic [1:0]       pv, ev;
    logic [63:0]      pi, pp, ei, ep;

    fetch_unit #(.XLEN(32), .FETCH_WIDTH(FW), .RESET_PC(32'h0)) dut (
      .clock            (clock),
      .reset            (reset),
      .i_redirect_valid (redir_v),
      .i_redirect_pc    (redir_pc),
      .i_stall          (stall),
      .o_mem_req_valid  (req_v),
      .o_mem_req_addr   (req_a),
      .i_mem_req_ready  (rdy),
      .i_mem_rsp_valid  (rsp_v),
      .i_mem_rsp_data   (rsp_d),
      .o_out_valid      (w_ov),
      .o_out_inst       (w_oi),
      .o_out_pc         (w_op),
      .i_out_ready      (out_ready)
    );

    assign req_v_a[g] = req_v;
    assign rdy_a[g]   = rdy;
    assign req_a_a[g] = req_a;
    assign ov[g]      = 2'(w_ov);
    assign oi[g]      = 64'(w_oi);
    assign op[g]      = 64'(w_op);

    // Memory: decides acceptance from the settled pre-edge values, updates after the edge.
    initial forever begin
      @(negedge clock);
      acc = req_v && rdy && !reset;
      if (reset) busy = 1'b0;
      @(posedge clock);
      #1;
      rsp_v = 1'b0;
      if (busy) begin
        if (m_lat == 0) begin
          rsp_v = 1'b1;
          rsp_d = {mword(m_addr + 32'd4), mword(m_addr)};
          busy  = 1'b0;
        end else begin
          m_lat--;
        end
      end
      if (acc) begin
        busy   = 1'b1;
        m_addr = req_a;
        m_lat  = rand_mem ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      if (reset) busy = 1'b0;
      rdy = rand_mem ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Consumer-side model: the stream of bundles must follow the PC sequence.
    initial forever begin
      @(negedge clock);
      if (reset) begin
        chk($sformatf("d%0d_req_in_reset", g), 64'(req_v), 64'(0));
        mpc       = 32'h0;
        hold_prev = 1'b0;
      end else begin
        if (stall || redir_v)
          chk($sformatf("d%0d_req_blocked", g), 64'(req_v), 64'(0));
        if (req_v && rdy) begin
          chk($sformatf("d%0d_req_addr", g), 64'(req_a), 64'({mpc[31:3], 3'b000}));
          chk($sformatf("d%0d_one_outstanding", g), 64'(busy), 64'(0));
        end
        if (hold_prev) begin
          chk($sformatf("d%0d_hold_valid", g), 64'(ov[g]), 64'(pv));
          chk($sformatf("d%0d_hold_inst", g), oi[g], pi);
          chk($sformatf("d%0d_hold_pc", g), op[g], pp);
        end
        xfer = (ov[g] != 2'b00) && out_ready && !redir_v;
        if (xfer) begin
          model_bundle(FW, mpc, ev, ei, ep, en);
          chk($sformatf("d%0d_bundle_valid", g), 64'(ov[g]), 64'(ev));
          chk($sformatf("d%0d_bundle_inst", g), oi[g], ei);
          chk($sformatf("d%0d_bundle_pc", g), op[g], ep);
          mpc = en;
          nx++;
        end
        hold_prev = (ov[g] != 2'b00) && !out_ready && !redir_v;
        pv = ov[g];
        pi = oi[g];
        pp = op[g];
        if (redir_v) mpc = redir_pc;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(int idx, logic [31:0] ea, string tag);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_v_a[idx] && rdy_a[idx]) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk({tag, "_seen"}, 64'(found), 64'(1));
    if (found) chk(tag, 64'(req_a_a[idx]), 64'(ea));
  endtask

  task automatic wait_out(int idx, logic [1:0] ev, logic [63:0] ei, logic [63:0] ep,
                          string tag);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ov[idx] != 2'b00) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk({tag, "_seen"}, 64'(found), 64'(1));
    if (found) begin
      chk({tag, "_valid"}, 64'(ov[idx]), 64'(ev));
      chk({tag, "_inst"}, oi[idx], ei);
      chk({tag, "_pc"}, op[idx], ep);
    end
  endtask

  task automatic redirect(logic [31:0] pc);
    tick();
    redir_v  = 1'b1;
    redir_pc = pc;
    tick();
    redir_v  = 1'b0;
  endtask

  initial begin
    logic [1:0]  sv;
    logic [63:0] si, sp;
    logic [31:0] r;
    reset = 1'b1; redir_v = 1'b0; redir_pc = '0; stall = 1'b0;
    out_ready = 1'b1; rand_mem = 1'b0; lat_cfg = 0;
    repeat (2) tick();
    chk("rst_valid", 64'(ov[0]), 64'(0));
    chk("rst_inst", oi[0], {32'h13, 32'h13});
    chk("rst_pc", op[0], 64'h0);
    chk("rst_inst_w1", oi[1], 64'h13);
    chk("rst_req", 64'(req_v_a[0]), 64'(0));
    reset = 1'b0;

    wait_req(0, 32'h0, "boot_addr");
    wait_out(0, 2'b11, {mword(32'h4), mword(32'h0)}, {32'h4, 32'h0}, "boot_bundle");
    wait_req(0, 32'h8, "boot_next");

    redirect(32'h104);
    wait_req(0, 32'h100, "odd_addr");
    wait_out(0, 2'b01, {32'h13, mword(32'h104)}, {32'h0, 32'h104}, "odd_bundle");
    wait_req(0, 32'h108, "odd_next");

    lat_cfg = 4;
    redirect(32'h40);
    wait_req(0, 32'h40, "drop_first");
    tick();
    redir_v = 1'b1; redir_pc = 32'h200;
    tick();
    redir_v = 1'b0;
    wait_req(0, 32'h200, "drop_next");
    wait_out(0, 2'b11, {mword(32'h204), mword(32'h200)}, {32'h204, 32'h200}, "drop_bundle");
    lat_cfg = 0;

    tick();
    out_ready = 1'b0;
    wait_out(0, 2'b11, {mword(32'h20c), mword(32'h208)}, {32'h20c, 32'h208}, "hold_bundle");
    sv = ov[0]; si = oi[0]; sp = op[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", 64'(ov[0]), 64'(sv));
      chk("hold_inst", oi[0], si);
      chk("hold_pc", op[0], sp);
      chk("hold_no_req", 64'(req_v_a[0]), 64'(0));
    end
    tick();
    out_ready = 1'b1;
    chk("hold_6th_valid", 64'(ov[0]), 64'(sv));
    tick();
    chk("hold_cleared", 64'(ov[0]), 64'(0));
    chk("hold_after_req", 64'(req_v_a[0]), 64'(1));
    chk("hold_after_addr", 64'(req_a_a[0]), 64'h210);

    tick();
    redir_v = 1'b1; redir_pc = 32'h300; stall = 1'b1;
    tick();
    redir_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_no_req", 64'(req_v_a[0]), 64'(0));
      tick();
    end
    stall = 1'b0;
    wait_req(0, 32'h300, "stall_release");
    wait_out(0, 2'b11, {mword(32'h304), mword(32'h300)}, {32'h304, 32'h300}, "stall_bundle");

    tick();
    out_ready = 1'b0; redir_v = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_v = 1'b0;
    wait_out(0, 2'b01, {32'h13, mword(32'hFFFF_FFFC)}, {32'h0, 32'hFFFF_FFFC}, "wrap_w2");
    wait_out(1, 2'b01, {32'h0, mword(32'hFFFF_FFFC)}, {32'h0, 32'hFFFF_FFFC}, "wrap_w1");
    tick();
    out_ready = 1'b1;
    wait_req(0, 32'h0, "wrap_next_w2");
    wait_req(1, 32'h0, "wrap_next_w1");

    rand_mem = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset     = ($urandom_range(0, 299) == 0);
      redir_v   = !reset && ($urandom_range(0, 15) == 0);
      r         = $urandom();
      redir_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | {27'h0, r[4:2], 2'b00})
                                              : {20'h0, r[11:2], 2'b00};
      stall     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    reset = 1'b0; redir_v = 1'b0; stall = 1'b0; out_ready = 1'b1;
    repeat (20) tick();
    chk("liveness_w2", 64'(g_inst[0].nx > 100), 64'(1));
    chk("liveness_w1", 64'(g_inst[1].nx > 100), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, address/PC width.
REQ-002 Parameter FETCH_WIDTH, 2, instruction lanes per bundle; legal values 1 or 2.
REQ-003 Parameter RESET_PC, 0, PC loaded on reset.
REQ-004 Reset is reset, synchronous, active-high; clock is clock.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 redirect_valid  in  1  branch/exception redirect.
REQ-008 redirect_pc  in  XLEN  redirect target, 4-byte aligned.
REQ-009 stall  in  1  inhibits new memory requests.
REQ-010 mem_req_valid  out  1  memory read request.
REQ-011 mem_req_addr  out  XLEN  request address, 8-byte aligned.
REQ-012 mem_req_ready  in  1  memory accepts request this cycle.
REQ-013 mem_rsp_valid  in  1  response data valid.
REQ-014 mem_rsp_data  in  64  fetched doubleword.
REQ-015 out_valid  out  FETCH_WIDTH  per-lane valid; lane 0 always oldest.
REQ-016 out_inst  out  FETCH_WIDTH*32  per-lane instruction.
REQ-017 out_pc  out  FETCH_WIDTH*XLEN  per-lane PC.
REQ-018 out_ready  in  1  consumer accepts whole bundle.

Function
REQ-019 FSM states REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-020 mem_req_valid = (state==REQ) & !stall & !redirect_valid; mem_req_addr = {pc[XLEN-1:3],3'b000}.
REQ-021 REQ->WAIT when mem_req_valid & mem_req_ready; else remain in REQ.
REQ-022 WAIT->HOLD on mem_rsp_valid with drop_pending=0; bundle registers, out_valid visible the following cycle.
REQ-023 Lane extraction, FETCH_WIDTH=2: pc[2]=0 -> lane0 = data[31:0] @pc, lane1 = data[63:32] @pc+4, next pc = pc+8; pc[2]=1 -> lane0 = data[63:32] @pc, lane1 invalid, next pc = pc+4.
REQ-024 Lane extraction, FETCH_WIDTH=1: lane0 = pc[2] ? data[63:32] : data[31:0]; next pc = pc+4.
REQ-025 Invalid lanes drive out_inst = NOP (32'h00000013) and out_pc = 0.
REQ-026 HOLD->REQ when out_ready & |out_valid; pc advances to next pc on this transfer; out_valid cleared the next cycle.
REQ-027 In HOLD without out_ready, all outputs remain stable.
REQ-028 redirect_valid has highest priority in every state: pc <= redirect_pc, state <= REQ, out_valid <= 0 next cycle.
REQ-029 Redirect in WAIT (or in REQ coincident with request acceptance) sets drop_pending; the next mem_rsp_valid is discarded and clears drop_pending; no new request issues until then.
REQ-030 Redirect coincident with mem_rsp_valid in WAIT: response discarded, drop_pending not set.
REQ-031 Redirect coincident with out_ready in HOLD: no transfer; consumer squashes likewise.
REQ-032 stall blocks only new requests; outstanding responses and HOLD handshakes proceed.
REQ-033 PC arithmetic is modulo 2^XLEN; wrap from 0xFFFFFFF8 to 0 is legal.

Reset
REQ-034 Reset: pc=RESET_PC, state=REQ, drop_pending=0, out_valid=0, out_inst=NOP, out_pc=0; mem_req_valid=0 during the reset cycle.
REQ-035 Reset mid-WAIT abandons the outstanding response; the memory model is reset concurrently.

Structure
REQ-036 Shared package holds XLEN, NOP constant, FETCH_STATE enum, and FETCH_LANE typedef {valid, inst[31:0], pc[XLEN-1:0]}.
REQ-037 Lane extraction is one combinational sub-module, fetch_align (inputs pc, 64-bit data; outputs lanes, next pc).

Verification
REQ-038 Reset, RESET_PC=0, 1-cycle memory, out_ready=1 -> addr 0x0 issued; bundle {pc 0x0, pc 0x4}; next request addr 0x8.
REQ-039 redirect_pc=0x104, FETCH_WIDTH=2 -> addr 0x100; lane0 = data[63:32] @0x104, lane1 invalid/NOP; next addr 0x108.
REQ-040 Redirect to 0x200 while in WAIT for 0x40 -> 0x40 response dropped, no bundle; next request addr 0x200.
REQ-041 out_ready=0 for 5 cycles in HOLD -> out_* stable; no mem_req_valid; transfer on 6th cycle.
REQ-042 stall=1 in REQ for 3 cycles -> mem_req_valid=0 throughout; request for same addr on stall deassert.
REQ-043 FETCH_WIDTH=1, pc 0xFFFFFFFC -> single lane data[63:32]; next pc 0x0.
